// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch program-counter generator for the IF stage.
//
// Produces the instruction-memory fetch address and the IF/ID control pulses.
// Three states:
//   BOOT : one clock after reset release, all inputs ignored
//   RUN  : live fetching with prioritised trap/redirect/halt/advance
//   HALT : PC frozen until resume_i or trap_valid
//
// Parameters
//   XLEN          width of the PC and redirect targets
//   RESET_VECTOR  first fetch address after reset
//   TRAP_VECTOR   trap handler address (also taken on a misaligned redirect)
//   IALIGN        instruction alignment / sequential step in bytes (2 or 4)
//   CNT_W         width of the accepted-fetch counter
//
// Ports
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   stall_i         hazard stall, holds the PC
//   if_ready        instruction memory accepts the current fetch
//   redirect_valid  taken branch/jump from EX
//   redirect_target branch/jump target address
//   trap_valid      exception/interrupt request
//   halt_i          enter HALT (ebreak/debug)
//   resume_i        leave HALT
//   pc              current fetch address (registered)
//   pc_plus         pc + IALIGN, combinational, wraps modulo 2^XLEN
//   pc_valid        pc is a live fetch request (registered, high in RUN)
//   flush_if        one-cycle pulse: pc was just redirected, discard IF/ID
//   misalign_err    one-cycle pulse: a redirect target was misaligned
//   fetch_count     number of accepted fetches, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned          IALIGN       = 4,
  parameter int unsigned          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_i,
  input  logic             if_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus,
  output logic             pc_valid,
  output logic             flush_if,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Sequential step and the mask of address bits that must be zero on a
  // legal target; IALIGN=2 checks bit 0, IALIGN=4 checks bits [1:0].
  localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  state_t           state_r;
  logic [XLEN-1:0]  pc_r;
  logic             pc_valid_r;
  logic             flush_r;
  logic             misalign_r;
  logic [CNT_W-1:0] count_r;

  logic             target_misaligned_s;
  logic             fetch_accept_s;
  logic [XLEN-1:0]  pc_plus_s;

  // Next sequential address, alignment check and fetch handshake.
  always_comb begin
    pc_plus_s           = pc_r + STEP;
    target_misaligned_s = ((redirect_target & ALIGN_MASK) != {XLEN{1'b0}});
    fetch_accept_s      = pc_valid_r & if_ready & ~stall_i;
  end

  // Control FSM together with every registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_VECTOR;
      pc_valid_r <= 1'b0;
      flush_r    <= 1'b0;
      misalign_r <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
    end else begin
      // Pulses are cleared unless a branch below sets them this cycle.
      flush_r    <= 1'b0;
      misalign_r <= 1'b0;
      case (state_r)
        BOOT: begin
          state_r    <= RUN;
          pc_r       <= RESET_VECTOR;
          pc_valid_r <= 1'b1;
        end
        RUN: begin
          // Trap and redirect win over stall/if_ready; the in-flight fetch
          // is abandoned, so the counter does not advance on these paths.
          if (trap_valid) begin
            pc_r    <= TRAP_VECTOR;
            flush_r <= 1'b1;
          end else if (redirect_valid && !target_misaligned_s) begin
            pc_r    <= redirect_target;
            flush_r <= 1'b1;
          end else if (redirect_valid) begin
            pc_r       <= TRAP_VECTOR;
            flush_r    <= 1'b1;
            misalign_r <= 1'b1;
          end else if (halt_i) begin
            state_r    <= HALT;
            pc_valid_r <= 1'b0;
          end else if (fetch_accept_s) begin
            pc_r    <= pc_plus_s;
            count_r <= count_r + CNT_W'(1);
          end else begin
            pc_r <= pc_r;
          end
        end
        HALT: begin
          // redirect_valid and halt_i carry no meaning while halted.
          if (trap_valid) begin
            state_r    <= RUN;
            pc_r       <= TRAP_VECTOR;
            pc_valid_r <= 1'b1;
            flush_r    <= 1'b1;
          end else if (resume_i) begin
            state_r    <= RUN;
            pc_valid_r <= 1'b1;
          end else begin
            state_r <= HALT;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean boot.
          state_r    <= BOOT;
          pc_r       <= RESET_VECTOR;
          pc_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = pc_r;
  assign pc_plus      = pc_plus_s;
  assign pc_valid     = pc_valid_r;
  assign flush_if     = flush_r;
  assign misalign_err = misalign_r;
  assign fetch_count  = count_r;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed self-checking bench for pc_gen.
// Expected values are queued as each step is driven and checked after the
// following rising edge. A second instance with IALIGN=2 shares the stimulus
// and is checked only where the alignment difference matters.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic        halt_i;
  logic        resume_i;

  logic [31:0] pc, pc_plus, fetch_count;
  logic        pc_valid, flush_if, misalign_err;

  logic [31:0] pc2, pc_plus2, fetch_count2;
  logic        pc_valid2, flush_if2, misalign_err2;

  int n_cmp;
  int n_fail;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  pc_gen #(.IALIGN(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .halt_i(halt_i), .resume_i(resume_i),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid), .flush_if(flush_if),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  pc_gen #(.IALIGN(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .halt_i(halt_i), .resume_i(resume_i),
    .pc(pc2), .pc_plus(pc_plus2), .pc_valid(pc_valid2), .flush_if(flush_if2),
    .misalign_err(misalign_err2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: observe = pc;
      1: observe = {31'd0, pc_valid};
      2: observe = {31'd0, flush_if};
      3: observe = {31'd0, misalign_err};
      4: observe = fetch_count;
      5: observe = pc2;
      6: observe = {31'd0, misalign_err2};
      7: observe = pc_plus;
      default: observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  // Queue the full registered-output picture of the primary instance.
  task automatic push_all(input string tag, input logic [31:0] e_pc,
                          input logic e_v, input logic e_fl,
                          input logic e_mis, input logic [31:0] e_cnt);
    push({tag, ".pc"}, 0, e_pc);
    push({tag, ".pc_valid"}, 1, {31'd0, e_v});
    push({tag, ".flush_if"}, 2, {31'd0, e_fl});
    push({tag, ".misalign_err"}, 3, {31'd0, e_mis});
    push({tag, ".fetch_count"}, 4, e_cnt);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0; if_ready = 1'b1; redirect_valid = 1'b0;
    redirect_target = 32'h0; trap_valid = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    idle_inputs();
    #12;
    push_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    drain();

    // Release between edges; BOOT edge leaves pc at the reset vector.
    @(negedge clk);
    reset_n = 1'b1;
    push_all("boot", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    push("pc_plus0", 7, 32'h4);
    drain();
    push_all("seq1", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);  step();
    push_all("seq2", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);  step();
    push_all("seq3", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);  step();
    push_all("seq4", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4); step();

    // Stall holds pc and count.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_all("stall", 32'h10, 1'b1, 1'b0, 1'b0, 32'd4);
      step();
    end
    redirect_valid = 1'b1; redirect_target = 32'h80;
    push_all("redir_stall", 32'h80, 1'b1, 1'b1, 1'b0, 32'd4);
    step();
    idle_inputs();
    push_all("after_redir", 32'h84, 1'b1, 1'b0, 1'b0, 32'd5);
    step();

    // Trap beats redirect.
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    push_all("trap_vs_redir", 32'h100, 1'b1, 1'b1, 1'b0, 32'd5);
    step();

    // Misaligned target: IALIGN=4 traps, IALIGN=2 follows it.
    idle_inputs();
    redirect_valid = 1'b1; redirect_target = 32'h202;
    push_all("misalign4", 32'h100, 1'b1, 1'b1, 1'b1, 32'd5);
    push("misalign2.pc", 5, 32'h202);
    push("misalign2.err", 6, 32'd0);
    step();
    idle_inputs(); if_ready = 1'b0;
    push_all("not_ready", 32'h100, 1'b1, 1'b0, 1'b0, 32'd5);
    step();

    // Top-of-space wrap.
    idle_inputs();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    push_all("to_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'd5);
    step();
    push("pc_plus_wrap", 7, 32'h0);
    drain();
    idle_inputs();
    push_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 32'd6);
    step();

    // Halt: pc frozen, no counting, redirect ignored.
    halt_i = 1'b1;
    push_all("halt", 32'h0, 1'b0, 1'b0, 1'b0, 32'd6);
    step();
    halt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      redirect_valid = (i == 2);
      redirect_target = 32'h300;
      push_all("halted", 32'h0, 1'b0, 1'b0, 1'b0, 32'd6);
      step();
    end
    idle_inputs(); resume_i = 1'b1;
    push_all("resume", 32'h0, 1'b1, 1'b0, 1'b0, 32'd6);
    step();
    idle_inputs();
    push_all("post_resume", 32'h4, 1'b1, 1'b0, 1'b0, 32'd7);
    step();

    // Redirect wins over a coincident halt.
    halt_i = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    push_all("halt_vs_redir", 32'h40, 1'b1, 1'b1, 1'b0, 32'd7);
    step();
    idle_inputs(); halt_i = 1'b1;
    push_all("halt2", 32'h40, 1'b0, 1'b0, 1'b0, 32'd7);
    step();
    idle_inputs(); trap_valid = 1'b1;
    push_all("trap_in_halt", 32'h100, 1'b1, 1'b1, 1'b0, 32'd7);
    step();
    idle_inputs();
    push_all("after_trap", 32'h104, 1'b1, 1'b0, 1'b0, 32'd8);
    step();

    // Asynchronous reset between edges, then BOOT ignores inputs.
    #3;
    reset_n = 1'b0;
    #1;
    push_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
    drain();
    @(negedge clk);
    reset_n = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h500; trap_valid = 1'b1;
    push_all("reboot", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    idle_inputs();
    push_all("reboot_seq", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
